// File: rtl/pulso_medidor.sv
// pulso_medidor: measures the high time, in Clk cycles, of pulses on an
// asynchronous line and reports each result through a valid/ack handshake.
module pulso_medidor #(
  parameter int unsigned W           = 18,
  parameter int unsigned MIN_LEN     = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic         Pulse_in,
  input  logic         Ack,
  output logic [W-1:0] Width,
  output logic         Valid,
  output logic         Short,
  output logic         Ovf,
  output logic         Busy
);

  localparam logic [W-1:0] CNT_MAX = '1;
  localparam logic [W-1:0] MIN_W   = W'(MIN_LEN);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    HOLD    = 2'd2
  } state_t;

  state_t                 state, state_nxt;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   ps, ps_d, rise_c;
  logic [W-1:0]           cnt, cnt_nxt;
  logic [W-1:0]           width_nxt;
  logic                   valid_nxt, short_nxt, ovf_nxt, busy_nxt;

  assign ps     = sync_q[SYNC_STAGES-1];
  assign rise_c = ps & ~ps_d;

  // Synchronize the asynchronous line and keep a one-cycle delayed copy for edge detection
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      sync_q <= '0;
      ps_d   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], Pulse_in};
      ps_d   <= ps;
    end
  end

  // State, counter and registered result outputs
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state <= IDLE;
      cnt   <= '0;
      Width <= '0;
      Valid <= 1'b0;
      Short <= 1'b0;
      Ovf   <= 1'b0;
      Busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      Width <= width_nxt;
      Valid <= valid_nxt;
      Short <= short_nxt;
      Ovf   <= ovf_nxt;
      Busy  <= busy_nxt;
    end
  end

  // Next-state logic: arm on a fresh rise, count while high, publish on fall, wait for Ack
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    width_nxt = Width;
    valid_nxt = Valid;
    short_nxt = Short;
    ovf_nxt   = Ovf;
    unique case (state)
      IDLE: begin
        if (rise_c) begin
          cnt_nxt   = W'(1);
          state_nxt = MEASURE;
        end
      end
      MEASURE: begin
        if (ps) begin
          // Saturate rather than wrap so long pulses stay recognisable
          cnt_nxt = (cnt == CNT_MAX) ? cnt : cnt + W'(1);
        end else begin
          width_nxt = cnt;
          short_nxt = (cnt < MIN_W);
          ovf_nxt   = (cnt == CNT_MAX);
          valid_nxt = 1'b1;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (Ack) begin
          valid_nxt = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    busy_nxt = (state_nxt == MEASURE);
  end

endmodule

// File: tb/tb_pulso_medidor.sv
// Self-checking bench for pulso_medidor: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a model.
module tb_pulso_medidor;

  localparam int unsigned SYNC    = 2;
  localparam int unsigned MIN_LEN = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pulse_in = 1'b0;
  logic        ack = 1'b0;

  logic [17:0] width_a;
  logic        valid_a, short_a, ovf_a, busy_a;
  logic [3:0]  width_b;
  logic        valid_b, short_b, ovf_b, busy_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pulso_medidor #(.W(18), .MIN_LEN(MIN_LEN), .SYNC_STAGES(SYNC)) dut_a (
    .Clk(clk), .Rst(rst), .Pulse_in(pulse_in), .Ack(ack),
    .Width(width_a), .Valid(valid_a), .Short(short_a), .Ovf(ovf_a), .Busy(busy_a)
  );

  pulso_medidor #(.W(4), .MIN_LEN(MIN_LEN), .SYNC_STAGES(SYNC)) dut_b (
    .Clk(clk), .Rst(rst), .Pulse_in(pulse_in), .Ack(ack),
    .Width(width_b), .Valid(valid_b), .Short(short_b), .Ovf(ovf_b), .Busy(busy_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: the line as seen SYNC edges late, measured as run lengths
  bit   hist[$];
  bit   m_ps, prev_ps, measuring, holding;
  int   run;
  logic m_valid, m_busy, m_short, m_ovf_a, m_ovf_b;
  logic [17:0] m_w_a;
  logic [3:0]  m_w_b;

  initial begin
    prev_ps = 0; measuring = 0; holding = 0; run = 0;
    m_valid = 0; m_busy = 0; m_short = 0; m_ovf_a = 0; m_ovf_b = 0;
    m_w_a = '0; m_w_b = '0;
  end

  always @(posedge clk) begin
    if (rst) begin
      hist.delete();
      prev_ps = 0; measuring = 0; holding = 0; run = 0;
      m_valid = 0; m_busy = 0; m_short = 0; m_ovf_a = 0; m_ovf_b = 0;
      m_w_a = '0; m_w_b = '0;
    end else begin
      m_ps = (hist.size() >= SYNC) ? hist[0] : 1'b0;
      hist.push_back(pulse_in);
      if (hist.size() > SYNC) void'(hist.pop_front());
      if (holding) begin
        if (ack) begin
          holding = 0;
          m_valid = 0;
        end
      end else if (measuring) begin
        if (m_ps) run++;
        else begin
          measuring = 0;
          holding   = 1;
          m_valid   = 1;
          m_w_a     = 18'(run);
          m_w_b     = (run > 15) ? 4'd15 : 4'(run);
          m_short   = (run < int'(MIN_LEN));
          m_ovf_a   = (run >= 262143);
          m_ovf_b   = (run >= 15);
        end
      end else if (m_ps && !prev_ps) begin
        measuring = 1;
        run       = 1;
      end
      prev_ps = m_ps;
      m_busy  = measuring;
    end
  end

  // Per-cycle comparison of both instances against the model
  always @(negedge clk) begin
    if (rst) begin
      chk("cycle_a", 32'({valid_a, busy_a, short_a, ovf_a, width_a}), 32'd0);
      chk("cycle_b", 32'({valid_b, busy_b, short_b, ovf_b, width_b}), 32'd0);
    end else begin
      chk("cycle_a", 32'({valid_a, busy_a, short_a, ovf_a, width_a}),
          32'({m_valid, m_busy, m_short, m_ovf_a, m_w_a}));
      chk("cycle_b", 32'({valid_b, busy_b, short_b, ovf_b, width_b}),
          32'({m_valid, m_busy, m_short, m_ovf_b, m_w_b}));
    end
  end

  task automatic send_pulse(input int n);
    @(negedge clk);
    pulse_in = 1'b1;
    repeat (n) @(negedge clk);
    pulse_in = 1'b0;
  endtask

  task automatic wait_valid(input int max_cycles);
    bit seen;
    seen = 0;
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clk);
      if (valid_a) begin
        seen = 1;
        break;
      end
    end
    chk("wait_valid", 32'(seen), 32'd1);
  endtask

  task automatic ack_once();
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    chk("ack_clears_valid", 32'(valid_a), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bit lvl;
    int seg;

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_outputs", 32'({valid_a, busy_a, short_a, ovf_a, width_a}), 32'd0);
    #1 rst = 1'b0;

    // 10-cycle pulse with Ack tied high: one-cycle Valid, 3 edges after the fall
    ack = 1'b1;
    send_pulse(10);
    @(negedge clk); chk("lat_valid_e0", 32'(valid_a), 32'd0);
    @(negedge clk); chk("lat_valid_e1", 32'(valid_a), 32'd0);
    @(negedge clk);
    chk("p10_valid", 32'(valid_a), 32'd1);
    chk("p10_width", 32'(width_a), 32'd10);
    chk("p10_flags", 32'({short_a, ovf_a}), 32'd0);
    chk("p10_width_b", 32'(width_b), 32'd10);
    @(negedge clk); chk("p10_valid_drop", 32'(valid_a), 32'd0);
    ack = 1'b0;

    // Short pulse held until Ack
    repeat (3) @(negedge clk);
    send_pulse(2);
    wait_valid(10);
    chk("p2_width", 32'(width_a), 32'd2);
    chk("p2_short", 32'(short_a), 32'd1);
    repeat (5) @(negedge clk);
    chk("p2_held", 32'(valid_a), 32'd1);
    ack_once();

    // Saturation on the narrow instance
    repeat (3) @(negedge clk);
    send_pulse(20);
    wait_valid(10);
    chk("p20_width_b", 32'(width_b), 32'd15);
    chk("p20_ovf_b", 32'(ovf_b), 32'd1);
    chk("p20_width_a", 32'(width_a), 32'd20);
    chk("p20_ovf_a", 32'(ovf_a), 32'd0);
    ack_once();

    // Pulse during HOLD is ignored; next pulse after Ack is measured
    repeat (3) @(negedge clk);
    send_pulse(9);
    wait_valid(10);
    chk("p9_width", 32'(width_a), 32'd9);
    repeat (2) @(negedge clk);
    send_pulse(5);
    repeat (6) @(negedge clk);
    chk("hold_ignore_valid", 32'(valid_a), 32'd1);
    chk("hold_ignore_width", 32'(width_a), 32'd9);
    ack_once();
    repeat (3) @(negedge clk);
    send_pulse(7);
    wait_valid(10);
    chk("p7_width", 32'(width_a), 32'd7);
    ack_once();

    // Asynchronous reset in HOLD clears outputs without a clock edge
    repeat (3) @(negedge clk);
    send_pulse(4);
    wait_valid(10);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 chk("async_rst_a", 32'({valid_a, busy_a, short_a, ovf_a, width_a}), 32'd0);
    chk("async_rst_b", 32'({valid_b, busy_b, short_b, ovf_b, width_b}), 32'd0);
    @(negedge clk);
    @(negedge clk);
    #1 rst = 1'b0;

    // One-cycle reset near the end of a long pulse aborts it
    ack = 1'b1;
    @(negedge clk);
    pulse_in = 1'b1;
    repeat (48) @(negedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    #1 rst = 1'b0;
    pulse_in = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("abort_no_valid", 32'(valid_a), 32'd0);
    end
    ack = 1'b0;
    send_pulse(6);
    wait_valid(10);
    chk("p6_width", 32'(width_a), 32'd6);
    ack_once();

    // Randomized traffic, checked every cycle by the model
    lvl = 0;
    seg = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      #1;
      if (seg == 0) begin
        lvl = ~lvl;
        seg = lvl ? int'($urandom_range(1, 22)) : int'($urandom_range(1, 10));
      end
      pulse_in = lvl;
      seg--;
      ack = ($urandom_range(0, 3) == 0);
      rst = ($urandom_range(0, 599) == 0);
    end
    @(negedge clk);
    #1;
    rst = 1'b0;
    pulse_in = 1'b0;
    repeat (5) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
